rank_sorter: RTL and testbench

- Sits directly downstream of the PageRank stage and consumes its converged node values.
- Stores N node values, sorts them in descending rank order with a sequential odd-even transposition network, then streams out (value, node index) pairs highest-rank first.
- Valid/ready handshake on both input and output. Processes one batch at a time.

---
 rtl/rank_sorter.sv | 140 ++++++++++++++
 tb/tb_rank_sorter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_sorter.sv
// rank_sorter: buffers N node values, sorts them descending (stable) with a sequential odd-even transposition network, streams (value, index) out.
// Latency: out_valid first rises N+1 cycles after the Nth accept; with SORT_EARLY_EXIT_EN defined a presorted batch needs only 3.
// Backpressure: in_ready only in LOAD; in DRAIN the head entry holds while out_ready is low. Optional macro: SORT_EARLY_EXIT_EN.
module rank_sorter #(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  state_t           r_state;
  logic [IDXW-1:0]  r_lcnt;
  logic [IDXW-1:0]  r_phase;
  logic [IDXW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_val [N];
  logic [IDXW-1:0]  r_idx [N];

  logic [WIDTH-1:0] w_nval [N];
  logic [IDXW-1:0]  w_nidx [N];
  logic             w_in_fire;
  logic             w_out_fire;

`ifdef SORT_EARLY_EXIT_EN
  logic             w_swap;
  logic             r_clean;  // previous phase made no swap
`endif

  assign in_ready   = (r_state == LOAD);
  assign out_valid  = (r_state == DRAIN);
  assign busy       = (r_state != LOAD);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign out_val    = out_valid ? r_val[r_ptr] : '0;
  assign out_idx    = out_valid ? r_idx[r_ptr] : '0;
  assign out_last   = out_valid && (r_ptr == LAST);

  // One transposition phase: compare-exchange the pairs selected by phase parity.
  // Strict '>' leaves equal values in arrival order, so the sort is stable.
  always_comb begin
    w_nval = r_val;
    w_nidx = r_idx;
`ifdef SORT_EARLY_EXIT_EN
    w_swap = 1'b0;
`endif
    for (int j = 0; j < N - 1; j++) begin
      if ((j[0] == r_phase[0]) && (r_val[j+1] > r_val[j])) begin
        w_nval[j]   = r_val[j+1];
        w_nval[j+1] = r_val[j];
        w_nidx[j]   = r_idx[j+1];
        w_nidx[j+1] = r_idx[j];
`ifdef SORT_EARLY_EXIT_EN
        w_swap      = 1'b1;
`endif
      end
    end
  end

  // Control FSM: load counter, sort phase counter, drain pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
      r_lcnt  <= '0;
      r_phase <= '0;
      r_ptr   <= '0;
`ifdef SORT_EARLY_EXIT_EN
      r_clean <= 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD: begin
`ifdef SORT_EARLY_EXIT_EN
          r_clean <= 1'b0;
`endif
          if (w_in_fire) begin
            if (r_lcnt == LAST) begin
              r_lcnt  <= '0;
              r_phase <= '0;
              r_state <= SORT;
            end else begin
              r_lcnt <= r_lcnt + IDXW'(1);
            end
          end
        end
        SORT: begin
          r_phase <= r_phase + IDXW'(1);
`ifdef SORT_EARLY_EXIT_EN
          r_clean <= ~w_swap;
          // Two clean phases in a row (one of each parity) mean the batch is ordered
          if ((r_phase == LAST) || (r_clean && !w_swap)) begin
`else
          if (r_phase == LAST) begin
`endif
            r_phase <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            if (r_ptr == LAST) begin
              r_ptr   <= '0;
              r_state <= LOAD;
            end else begin
              r_ptr <= r_ptr + IDXW'(1);
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  // Slot storage: written by arrivals in LOAD, rewritten by each phase in SORT
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_in_fire) begin
        r_val[r_lcnt] <= in_val;
        r_idx[r_lcnt] <= r_lcnt;
      end else if (r_state == SORT) begin
        r_val <= w_nval;
        r_idx <= w_nidx;
      end
    end
  end

endmodule

// File: tb/tb_rank_sorter.sv
// Bench for rank_sorter: directed batches, a stable-sort reference model and
// a per-cycle compare process, plus literal expectations on captured output.
module tb_rank_sorter;
  localparam int N  = 16;
  localparam int W  = 16;
  localparam int IW = 4;
`ifdef SORT_EARLY_EXIT_EN
  localparam int LAT_PRESORTED = 3;
  localparam int LAT_GENERAL   = -1;
`else
  localparam int LAT_PRESORTED = 17;
  localparam int LAT_GENERAL   = 17;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_val = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_val;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  rank_sorter #(.N(N), .WIDTH(W), .IDXW(IW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [W-1:0] v; logic [IW-1:0] i; } ent_t;

  logic [W-1:0] ld_q[$];
  logic [W-1:0] exp_val[N];
  int           exp_idx[N];
  ent_t         out_log[$];
  bit           pending = 0;
  bit           first = 0;
  int           pos = 0;
  int           t_acc = 0;
  int           exp_lat = -1;
  int           batches = 0;
  bit           prev_stall = 0;
  logic [W-1:0]  prev_val = '0;
  logic [IW-1:0] prev_idx = '0;
  bit           tog = 0;

  // Descending order, ties resolved by lower arrival index first
  function automatic void build_expect();
    bit used[N] = '{default: 1'b0};
    for (int k = 0; k < N; k++) begin
      int best = -1;
      for (int i = 0; i < N; i++)
        if (!used[i] && (best < 0 || ld_q[i] > ld_q[best])) best = i;
      used[best] = 1'b1;
      exp_val[k] = ld_q[best];
      exp_idx[k] = best;
    end
  endfunction

  // Compare process: checks every cycle, then advances the model on handshakes
  always @(negedge clk) begin
    if (reset) begin
      ld_q.delete();
      pending    = 0;
      pos        = 0;
      prev_stall = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!pending));
      chk("busy", 32'(busy), 32'(pending));
      if (out_valid) begin
        if (!pending) begin
          chk("out_valid_unexpected", 32'(out_valid), 32'(0));
        end else begin
          if (first) begin
            if (exp_lat >= 0) chk("first_out_latency", 32'(cyc - t_acc), 32'(exp_lat));
            first = 0;
          end
          chk("out_val", 32'(out_val), 32'(exp_val[pos]));
          chk("out_idx", 32'(out_idx), 32'(exp_idx[pos]));
          chk("out_last", 32'(out_last), 32'(pos == N - 1));
          if (prev_stall) begin
            chk("hold_val", 32'(out_val), 32'(prev_val));
            chk("hold_idx", 32'(out_idx), 32'(prev_idx));
          end
          if (out_ready) begin
            out_log.push_back('{v: out_val, i: out_idx});
            pos++;
            if (pos == N) begin
              pending = 0;
              pos     = 0;
              batches++;
            end
          end
        end
        prev_stall = !out_ready;
        prev_val   = out_val;
        prev_idx   = out_idx;
      end else begin
        chk("idle_out_val", 32'(out_val), 32'(0));
        chk("idle_out_idx", 32'(out_idx), 32'(0));
        chk("idle_out_last", 32'(out_last), 32'(0));
        prev_stall = 0;
      end
      if (in_valid && in_ready) begin
        ld_q.push_back(in_val);
        if (ld_q.size() == N) begin
          build_expect();
          ld_q.delete();
          pending = 1;
          first   = 1;
          pos     = 0;
          t_acc   = cyc;
        end
      end
    end
  end

  // out_ready pattern: steady high, or alternating 1,0,1,0
  always @(posedge clk) begin
    #1;
    if (tog) out_ready = ~out_ready;
    else     out_ready = 1'b1;
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] stim[N];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] v);
    int tries = 0;
    in_valid = 1'b1;
    in_val   = v;
    @(negedge clk);
    while (!in_ready && tries < 100) begin
      tries++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_val   = 16'hDEAD;
  endtask

  task automatic load_batch(input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps && i < 8) repeat (1 + i % 3) tick();
      send(stim[i]);
    end
  endtask

  task automatic wait_done(input int b0);
    int n = 0;
    while (batches == b0 && n < 300) begin
      tick();
      n++;
    end
    if (batches == b0) chk("drain_timeout", 32'(0), 32'(1));
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0;
    logic [N-1:0] seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_val", 32'(out_val), 32'(0));
    chk("rst_out_idx", 32'(out_idx), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    tick();

    // 1: ascending 0x0100*i -> idx 15..0
    for (int i = 0; i < N; i++) stim[i] = 16'(i * 256);
    exp_lat = 17;
    out_log.delete();
    b0 = batches;
    load_batch(0);
    wait_done(b0);
    chk("t1_count", 32'(out_log.size()), 32'(N));
    for (int k = 0; k < N && k < out_log.size(); k++) begin
      chk("t1_idx", 32'(out_log[k].i), 32'(15 - k));
      chk("t1_val", 32'(out_log[k].v), 32'((15 - k) * 256));
    end

    // 2: all equal -> arrival order kept
    for (int i = 0; i < N; i++) stim[i] = 16'h1000;
    exp_lat = LAT_PRESORTED;
    out_log.delete();
    b0 = batches;
    load_batch(0);
    wait_done(b0);
    chk("t2_count", 32'(out_log.size()), 32'(N));
    for (int k = 0; k < N && k < out_log.size(); k++) begin
      chk("t2_idx", 32'(out_log[k].i), 32'(k));
      chk("t2_val", 32'(out_log[k].v), 32'(16'h1000));
    end

    // 3: random batch with duplicates, out_ready toggling
    for (int i = 0; i < N; i++) stim[i] = 16'($urandom_range(0, 11)) << 12 | 16'($urandom_range(0, 1));
    exp_lat = LAT_GENERAL;
    out_log.delete();
    tog = 1;
    b0 = batches;
    load_batch(0);
    wait_done(b0);
    tog = 0;
    tick();
    chk("t3_count", 32'(out_log.size()), 32'(N));
    seen = '0;
    for (int k = 0; k < out_log.size(); k++) begin
      seen[out_log[k].i] = 1'b1;
      if (k > 0) chk("t3_nonincreasing", 32'(out_log[k].v <= out_log[k-1].v), 32'(1));
    end
    chk("t3_all_idx_once", 32'(seen), 32'(16'hFFFF));

    // 4: first 8 with gaps, then back-to-back
    for (int i = 0; i < N; i++) stim[i] = 16'($urandom_range(0, 16'hFFFF));
    exp_lat = LAT_GENERAL;
    out_log.delete();
    b0 = batches;
    load_batch(1);
    wait_done(b0);
    chk("t4_count", 32'(out_log.size()), 32'(N));

    // 5: reset in SORT at t+5, then a fresh batch
    for (int i = 0; i < N; i++) stim[i] = 16'hFFFF;
    b0 = batches;
    load_batch(0);           // now 1ns into cycle t+1
    repeat (4) tick();       // cycle t+5
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_in_ready", 32'(in_ready), 32'(1));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_out_valid", 32'(out_valid), 32'(0));
    chk("t5_no_batch_done", 32'(batches), 32'(b0));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) stim[i] = 16'(((i * 7) % 16) * 16'h0111);
    exp_lat = LAT_GENERAL;
    out_log.delete();
    b0 = batches;
    load_batch(0);
    wait_done(b0);
    chk("t5_count", 32'(out_log.size()), 32'(N));
    for (int k = 0; k < N && k < out_log.size(); k++)
      chk("t5_val", 32'(out_log[k].v), 32'((15 - k) * 16'h0111));

    // 6: descending (presorted)
    for (int i = 0; i < N; i++) stim[i] = 16'(16'hF000 - i * 16'h0100);
    exp_lat = LAT_PRESORTED;
    out_log.delete();
    b0 = batches;
    load_batch(0);
    wait_done(b0);
    chk("t6_count", 32'(out_log.size()), 32'(N));
    for (int k = 0; k < N && k < out_log.size(); k++)
      chk("t6_idx", 32'(out_log[k].i), 32'(k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
